// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port integer register file for PYGMY-V32I.
// NRD combinational read ports, NWR write ports (highest-index port wins on a
// same-register collision, flagged one cycle later on o_WCONF), and a clear
// engine that zeroes every entry after reset or on an i_CLEAR request.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-to-read bypass).
// When the macro is undefined, reads always return the stored array value.
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                               i_CLK,
    input  logic                               i_RSTn,
    input  logic                               i_CLEAR,
    input  logic [NWR-1:0]                     i_WE,
    input  logic [NWR*$clog2(NREGS)-1:0]       i_RD_PTR,
    input  logic [NWR*XLEN-1:0]                i_RD,
    input  logic [NRD*$clog2(NREGS)-1:0]       i_RS_PTR,
    output logic [NRD*XLEN-1:0]                o_RS,
    output logic                               o_READY,
    output logic                               o_WCONF
);

    localparam int AW = $clog2(NREGS);
    localparam logic [AW-1:0] CNT_LAST = AW'(NREGS - 1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     cnt_q,   cnt_d;
    logic              wconf_q, wconf_d;

    // Storage array; never reset asynchronously, the clear engine zeroes it.
    logic [XLEN-1:0]   mem_q [NREGS];
    logic [XLEN-1:0]   mem_d [NREGS];

    // Unpacked views of the write ports and their acceptance qualifiers.
    logic [AW-1:0]     wr_ptr  [NWR];
    logic [XLEN-1:0]   wr_data [NWR];
    logic [NWR-1:0]    wr_acc;

    // Per-lane read pointer and resolved data.
    logic [AW-1:0]     rs_ptr  [NRD];
    logic [XLEN-1:0]   rs_val  [NRD];

    // Unpack write ports and decide which writes are accepted this cycle:
    // only in RUN, never during a clear, and never to x0 when it is hardwired.
    always_comb begin
        wr_acc = '0;
        for (int k = 0; k < NWR; k++) begin
            wr_ptr[k]  = i_RD_PTR[k*AW +: AW];
            wr_data[k] = i_RD[k*XLEN +: XLEN];
            wr_acc[k]  = (state_q == ST_RUN) && !i_CLEAR && i_WE[k] &&
                         ((wr_ptr[k] != '0) || (ZERO_REG == 0));
        end
    end

    // Next-state logic for the clear engine: INIT walks the counter over every
    // entry, a clear request (in either state) restarts the walk from entry 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                if (i_CLEAR) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (i_CLEAR) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    // Flag any pair of accepted writes aimed at the same register.
    always_comb begin
        wconf_d = 1'b0;
        for (int a = 0; a < NWR; a++) begin
            for (int b = a + 1; b < NWR; b++) begin
                if (wr_acc[a] && wr_acc[b] && (wr_ptr[a] == wr_ptr[b])) begin
                    wconf_d = 1'b1;
                end
            end
        end
    end

    // Array update: the clear engine zeroes one entry per INIT cycle; in RUN the
    // ports are applied in ascending order so the highest-index port wins.
    always_comb begin
        mem_d = mem_q;
        if ((state_q == ST_INIT) && !i_CLEAR) begin
            mem_d[cnt_q] = '0;
        end else begin
            for (int k = 0; k < NWR; k++) begin
                if (wr_acc[k]) begin
                    mem_d[wr_ptr[k]] = wr_data[k];
                end
            end
        end
    end

    // Control state: asynchronous reset sends the engine back to INIT.
    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            wconf_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wconf_q <= wconf_d;
        end
    end

    // Storage register; contents are meaningful only once INIT has swept them.
    always_ff @(posedge i_CLK) begin
        mem_q <= mem_d;
    end

    // Combinational read lanes: INIT reads as zero, x0 reads zero when
    // hardwired, and the optional bypass forwards same-cycle accepted writes.
    always_comb begin
        o_RS = '0;
        for (int j = 0; j < NRD; j++) begin
            rs_ptr[j] = i_RS_PTR[j*AW +: AW];
            rs_val[j] = mem_q[rs_ptr[j]];
`ifdef REGFILE_BYPASS_EN
            for (int k = 0; k < NWR; k++) begin
                if (wr_acc[k] && (wr_ptr[k] == rs_ptr[j])) begin
                    rs_val[j] = wr_data[k];
                end
            end
`else
            rs_val[j] = mem_q[rs_ptr[j]];
`endif
            if (state_q != ST_RUN) begin
                rs_val[j] = '0;
            end
            if ((ZERO_REG != 0) && (rs_ptr[j] == '0)) begin
                rs_val[j] = '0;
            end
            o_RS[j*XLEN +: XLEN] = rs_val[j];
        end
    end

    assign o_READY = (state_q == ST_RUN);
    assign o_WCONF = wconf_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Testbench for regfile_mp: two instances (ZERO_REG=1 and ZERO_REG=0) share
// the same stimulus and are compared against a behavioural model of the file.
module tb_regfile_mp;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int AW    = 5;

   logic              clk = 1'b0;
   logic              rstN;
   logic              clearReq;
   logic [1:0]        weVec;
   logic [2*AW-1:0]   wPtrVec;
   logic [2*XLEN-1:0] wDataVec;
   logic [2*AW-1:0]   rPtrVec;
   logic [2*XLEN-1:0] rsA, rsB;
   logic              readyA, readyB, wconfA, wconfB;

   int checks = 0;
   int failures = 0;

   // Behavioural model state shared by both instances (same FSM), with
   // separate storage and conflict flags because x0 behaves differently.
   logic [31:0] memA [NREGS];
   logic [31:0] memB [NREGS];
   bit          inInit;
   int          initCnt;
   bit          modelWconfA, modelWconfB;

   always #5 clk = ~clk;

   regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(2), .NWR(2), .ZERO_REG(1)) dut (
      .i_CLK(clk), .i_RSTn(rstN), .i_CLEAR(clearReq), .i_WE(weVec),
      .i_RD_PTR(wPtrVec), .i_RD(wDataVec), .i_RS_PTR(rPtrVec),
      .o_RS(rsA), .o_READY(readyA), .o_WCONF(wconfA));

   regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(2), .NWR(2), .ZERO_REG(0)) dutNz (
      .i_CLK(clk), .i_RSTn(rstN), .i_CLEAR(clearReq), .i_WE(weVec),
      .i_RD_PTR(wPtrVec), .i_RD(wDataVec), .i_RS_PTR(rPtrVec),
      .o_RS(rsB), .o_READY(readyB), .o_WCONF(wconfB));

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [AW-1:0] wPtr(input int k);
      return wPtrVec[k*AW +: AW];
   endfunction

   function automatic logic [31:0] wData(input int k);
      return wDataVec[k*XLEN +: XLEN];
   endfunction

   function automatic bit accepted(input int k, input bit zr);
      return !inInit && !clearReq && weVec[k] && ((wPtr(k) != 0) || !zr);
   endfunction

   // Expected read data for lane j of the instance with ZERO_REG = zr.
   function automatic logic [31:0] expLane(input int j, input bit zr);
      logic [AW-1:0] p;
      logic [31:0]   v;
      p = rPtrVec[j*AW +: AW];
      if (inInit) return 32'h0;
      if (zr && (p == 0)) return 32'h0;
      v = zr ? memA[p] : memB[p];
`ifdef REGFILE_BYPASS_EN
      for (int k = 0; k < 2; k++) begin
         if (accepted(k, zr) && (wPtr(k) == p)) v = wData(k);
      end
`endif
      return v;
   endfunction

   task automatic modelReset();
      inInit = 1'b1;
      initCnt = 0;
      modelWconfA = 1'b0;
      modelWconfB = 1'b0;
   endtask

   // Advance the model by one rising edge using the currently driven inputs.
   task automatic modelEdge();
      int hitsA [NREGS];
      int hitsB [NREGS];
      bit confA, confB;
      confA = 1'b0;
      confB = 1'b0;
      if (inInit) begin
         if (clearReq) begin
            initCnt = 0;
         end else begin
            memA[initCnt] = 32'h0;
            memB[initCnt] = 32'h0;
            initCnt++;
            if (initCnt == NREGS) inInit = 1'b0;
         end
      end else if (clearReq) begin
         inInit = 1'b1;
         initCnt = 0;
      end else begin
         for (int r = 0; r < NREGS; r++) begin
            hitsA[r] = 0;
            hitsB[r] = 0;
         end
         for (int k = 0; k < 2; k++) begin
            if (accepted(k, 1'b1)) begin
               memA[wPtr(k)] = wData(k);
               hitsA[wPtr(k)]++;
            end
            if (accepted(k, 1'b0)) begin
               memB[wPtr(k)] = wData(k);
               hitsB[wPtr(k)]++;
            end
         end
         for (int r = 0; r < NREGS; r++) begin
            if (hitsA[r] > 1) confA = 1'b1;
            if (hitsB[r] > 1) confB = 1'b1;
         end
      end
      modelWconfA = confA;
      modelWconfB = confB;
   endtask

   // Check all outputs mid-cycle, then let the edge happen and update the model.
   task automatic stepCycle(input string tag);
      @(negedge clk);
      checkOutput({tag, "/readyA"}, {31'b0, readyA}, {31'b0, !inInit});
      checkOutput({tag, "/readyB"}, {31'b0, readyB}, {31'b0, !inInit});
      checkOutput({tag, "/wconfA"}, {31'b0, wconfA}, {31'b0, modelWconfA});
      checkOutput({tag, "/wconfB"}, {31'b0, wconfB}, {31'b0, modelWconfB});
      checkOutput({tag, "/rs0A"}, rsA[31:0],  expLane(0, 1'b1));
      checkOutput({tag, "/rs1A"}, rsA[63:32], expLane(1, 1'b1));
      checkOutput({tag, "/rs0B"}, rsB[31:0],  expLane(0, 1'b0));
      checkOutput({tag, "/rs1B"}, rsB[63:32], expLane(1, 1'b0));
      @(posedge clk);
      modelEdge();
      #1;
   endtask

   task automatic applyStimulus(input logic [1:0] we,
                                input logic [AW-1:0] p0, input logic [31:0] d0,
                                input logic [AW-1:0] p1, input logic [31:0] d1,
                                input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                                input logic clr, input string tag);
      weVec    = we;
      wPtrVec  = {p1, p0};
      wDataVec = {d1, d0};
      rPtrVec  = {r1, r0};
      clearReq = clr;
      stepCycle(tag);
   endtask

   // Asynchronous reset pulse inside a cycle, away from both clock edges.
   task automatic pulseReset(input string tag);
      rstN = 1'b0;
      #2;
      modelReset();
      checkOutput({tag, "/rstReady"}, {31'b0, readyA}, 32'h0);
      checkOutput({tag, "/rstWconf"}, {31'b0, wconfA}, 32'h0);
      rstN = 1'b1;
   endtask

   // Hard bound on simulation time so the bench can never hang.
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog got=timeout expected=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rstN = 1'b0;
      clearReq = 1'b0;
      weVec = '0;
      wPtrVec = '0;
      wDataVec = '0;
      rPtrVec = '0;
      for (int r = 0; r < NREGS; r++) begin
         memA[r] = 32'h0;
         memB[r] = 32'h0;
      end
      modelReset();
      repeat (2) @(posedge clk);
      #1;
      pulseReset("reset");

      // Reset/init: write to x5 during INIT must be dropped.
      for (int i = 0; i < NREGS; i++)
         applyStimulus(2'b01, 5'd5, 32'h1234, 5'd0, 32'h0, 5'd5, 5'd5, 1'b0, "init");
      checkOutput("readyAfterInit", {31'b0, readyA}, 32'h1);
      applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd5, 5'd5, 1'b0, "x5read");

      // Dual write, distinct targets.
      applyStimulus(2'b11, 5'd3, 32'hAAAA_0001, 5'd4, 32'hBBBB_0002, 5'd3, 5'd4, 1'b0, "dualWr");
      applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd3, 5'd4, 1'b0, "dualRd");
      checkOutput("dualX3", rsA[31:0], 32'hAAAA_0001);

      // Write conflict on x7: port 1 wins and o_WCONF pulses once.
      applyStimulus(2'b11, 5'd7, 32'h11, 5'd7, 32'h22, 5'd7, 5'd3, 1'b0, "confWr");
      checkOutput("confPulse", {31'b0, wconfA}, 32'h1);
      applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd7, 5'd7, 1'b0, "confRd");
      checkOutput("confX7", rsA[31:0], 32'h22);
      applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd7, 5'd0, 1'b0, "confEnd");

      // Zero register: hardwired instance ignores it, the other stores it.
      applyStimulus(2'b01, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'h0, 5'd1, 5'd1, 1'b0, "x0Wr");
      applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, "x0Rd");
      checkOutput("x0NzRead", rsB[31:0], 32'hFFFF_FFFF);

      // Same-cycle write and read of x9.
      applyStimulus(2'b01, 5'd9, 32'hCAFE, 5'd0, 32'h0, 5'd9, 5'd9, 1'b0, "bypWr");
      applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 5'd9, 1'b0, "bypRd");

      // Fill x1..x31, then clear together with a dropped write to x2.
      for (int i = 1; i < NREGS; i += 2) begin
         if (i + 1 < NREGS)
            applyStimulus(2'b11, AW'(i), 32'h1000 + i, AW'(i + 1), 32'h1000 + i + 1,
                          AW'(i), AW'(i + 1), 1'b0, "fill");
         else
            applyStimulus(2'b01, AW'(i), 32'h1000 + i, 5'd0, 32'h0, AW'(i), 5'd2, 1'b0, "fill");
      end
      applyStimulus(2'b01, 5'd2, 32'h55, 5'd0, 32'h0, 5'd2, 5'd31, 1'b1, "clear");
      for (int i = 0; i < NREGS; i++)
         applyStimulus(2'b11, AW'(i), 32'hDEAD, 5'd2, 32'hBEEF, 5'd2, AW'(i), 1'b0, "clrInit");
      checkOutput("readyAfterClear", {31'b0, readyA}, 32'h1);
      for (int i = 0; i < NREGS; i += 2)
         applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, AW'(i), AW'(i + 1), 1'b0, "clrRd");

      // Reset mid-INIT restarts the full sweep.
      applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd1, 5'd2, 1'b1, "clr2");
      for (int i = 0; i < 10; i++)
         applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd1, 5'd2, 1'b0, "midInit");
      pulseReset("midRst");
      for (int i = 0; i < NREGS - 1; i++)
         applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd1, 5'd2, 1'b0, "reInit");
      checkOutput("notReadyEarly", {31'b0, readyA}, 32'h0);
      applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd1, 5'd2, 1'b0, "reInitLast");
      checkOutput("readyAfterReInit", {31'b0, readyA}, 32'h1);

      // Randomized traffic, pointers often confined to a few registers.
      for (int i = 0; i < 400; i++) begin
         logic [AW-1:0] p0, p1, r0, r1;
         bit narrow;
         narrow = ($urandom_range(0, 1) == 1);
         p0 = narrow ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, NREGS - 1));
         p1 = narrow ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, NREGS - 1));
         r0 = narrow ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, NREGS - 1));
         r1 = AW'($urandom_range(0, NREGS - 1));
         applyStimulus(2'($urandom_range(0, 3)), p0, $urandom, p1, $urandom, r0, r1,
                       ($urandom_range(0, 59) == 0), "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
